croc_boot_sequencer: RTL

//  Bring-up sequencer for the FPGA-wrapped croc SoC.

---
 rtl/croc_boot_sequencer_if.sv | 28 ++
 rtl/croc_boot_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/croc_boot_sequencer_if.sv
// Bring-up handshake between the boot sequencer and its environment:
// run request, PLL lock, SoC status in; SoC reset/fetch control and run
// supervision results out.
interface croc_boot_sequencer_if #(
    parameter int unsigned CntWidth = 24
);
    logic                start_i;
    logic                locked_i;
    logic                status_i;
    logic                soc_rst_no;
    logic                fetch_en_o;
    logic                done_o;
    logic                fault_o;
    logic [2:0]          state_o;
    logic [CntWidth-1:0] cycles_o;

    // The sequencer side.
    modport master (
        input  start_i, locked_i, status_i,
        output soc_rst_no, fetch_en_o, done_o, fault_o, state_o, cycles_o
    );

    // The VIO / SoC side.
    modport slave (
        output start_i, locked_i, status_i,
        input  soc_rst_no, fetch_en_o, done_o, fault_o, state_o, cycles_o
    );
endinterface

// File: rtl/croc_boot_sequencer.sv
// Bring-up sequencer for the FPGA-wrapped croc SoC. Filters the clock-wizard
// lock flag, holds the SoC in reset, releases it, enables instruction fetch
// and then supervises the run with a completion timeout.
module croc_boot_sequencer #(
    parameter int unsigned LockFilterCycles = 16,
    parameter int unsigned ResetHoldCycles  = 32,
    parameter int unsigned FetchDelayCycles = 8,
    parameter int unsigned TimeoutCycles    = 1048576,
    parameter int unsigned CntWidth         = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    croc_boot_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5,
        FAULT     = 3'd6
    } state_e;

    // Last timer value of each timed phase; the transition fires on it.
    localparam logic [CntWidth-1:0] LockLast    = CntWidth'(LockFilterCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast    = CntWidth'(ResetHoldCycles - 1);
    localparam logic [CntWidth-1:0] ReleaseLast = CntWidth'(FetchDelayCycles - 1);
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

    logic [1:0]          locked_sync_q;
    logic                locked;
    state_e              state_q, state_d;
    logic [CntWidth-1:0] timer_q, timer_d;
    logic [CntWidth-1:0] cycles_q, cycles_d;
    logic                soc_rst_n_q, fetch_en_q, done_q, fault_q;

    // Two-flop synchroniser for the asynchronous clock-wizard lock flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour; blocking ones would collapse the chain.
            locked_sync_q <= {locked_sync_q[0], bus.locked_i};
        end
    end

    assign locked = locked_sync_q[1];

    // Next-state, phase timer and cycle-count capture.
    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        cycles_d = cycles_q;

        if ((state_q inside {WAIT_LOCK, HOLD, RELEASE, RUN, DONE}) && !locked) begin
            // Lock loss restarts the filter, also when already filtering.
            state_d = WAIT_LOCK;
            timer_d = '0;
        end else if ((state_q != IDLE) && !bus.start_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d  = WAIT_LOCK;
                        cycles_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (timer_q == LockLast) state_d = HOLD;
                    else                     timer_d = timer_q + CntWidth'(1);
                end
                HOLD: begin
                    if (timer_q == HoldLast) state_d = RELEASE;
                    else                     timer_d = timer_q + CntWidth'(1);
                end
                RELEASE: begin
                    if (timer_q == ReleaseLast) state_d = RUN;
                    else                        timer_d = timer_q + CntWidth'(1);
                end
                RUN: begin
                    // Completion beats timeout when both land on the same cycle.
                    if (bus.status_i) begin
                        state_d  = DONE;
                        cycles_d = timer_q + CntWidth'(1);
                    end else if (timer_q == TimeoutLast) begin
                        state_d = FAULT;
                    end else begin
                        timer_d = timer_q + CntWidth'(1);
                    end
                end
                DONE, FAULT: begin
                    // Left only through abort (or lock loss for DONE).
                end
                default: state_d = IDLE;
            endcase
        end

        // Every phase starts counting from zero.
        if (state_d != state_q) timer_d = '0;
    end

    // State, timer and outputs; outputs decode the next state so they move
    // on the same edge as state_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cycles_q    <= '0;
            soc_rst_n_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cycles_q    <= cycles_d;
            soc_rst_n_q <= (state_d inside {RELEASE, RUN, DONE});
            fetch_en_q  <= (state_d inside {RUN, DONE});
            done_q      <= (state_d == DONE);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign bus.soc_rst_no = soc_rst_n_q;
    assign bus.fetch_en_o = fetch_en_q;
    assign bus.done_o     = done_q;
    assign bus.fault_o    = fault_q;
    assign bus.state_o    = state_q;
    assign bus.cycles_o   = cycles_q;

endmodule
